// File: rtl/sb_interlock_pkg.sv
// Shared scoreboard sizing: GPR count, register address width, counter widths.
package sb_interlock_pkg;

  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 32;

endpackage

// File: rtl/sb_interlock_counter.sv
// One GPR's pending-write counter: saturating up/down, flags overflow/underflow attempts.
// Coincident inc and dec cancel so an issue and a retire to the same register leave it unchanged.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_up;
  logic             w_down;

  always_comb begin
    w_full  = &r_cnt;
    w_empty = (r_cnt == '0);
    w_up    = inc && !dec;
    w_down  = dec && !inc;
    err     = (w_up && w_full) || (w_down && w_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_up && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_down && !w_empty) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sb_interlock.sv
// Register scoreboard for decode: holds ds_ready_go low while a source GPR has an in-flight write.
// Counts stall cycles and latches any counter overflow/underflow into a sticky error flag.
module sb_interlock
  import sb_interlock_pkg::*;
#(
  parameter int NREG   = sb_interlock_pkg::NREG,
  parameter int AW     = sb_interlock_pkg::AW,
  parameter int CNT_W  = sb_interlock_pkg::CNT_W,
  parameter int PERF_W = sb_interlock_pkg::PERF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic              ds_src1_used,
  input  logic [AW-1:0]     ds_src1_addr,
  input  logic              ds_src2_used,
  input  logic [AW-1:0]     ds_src2_addr,
  input  logic              ds_gr_we,
  input  logic [AW-1:0]     ds_dest,
  input  logic              es_allowin,
  input  logic              ws_rf_we,
  input  logic [AW-1:0]     ws_rf_waddr,
  output logic              ds_ready_go,
  output logic              sb_busy,
  output logic              sb_err,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [NREG-1:0]   w_err;
  logic              w_hz1;
  logic              w_hz2;
  logic              w_issue;
  logic              w_inc;
  logic              w_ret;
  logic              w_busy;
  logic              r_err;
  logic [PERF_W-1:0] r_stall_cnt;

  // r0 is hardwired zero: it has no counter and can never be a hazard.
  assign w_cnt[0] = '0;
  assign w_err[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc && (ds_dest == AW'(g))),
      .dec   (w_ret && (ws_rf_waddr == AW'(g))),
      .cnt   (w_cnt[g]),
      .err   (w_err[g])
    );
  end

  // No bypass from the writeback port: the counter drops on the same edge the regfile is written.
  always_comb begin
    w_hz1   = ds_src1_used && (ds_src1_addr != '0) && (w_cnt[ds_src1_addr] != '0);
    w_hz2   = ds_src2_used && (ds_src2_addr != '0) && (w_cnt[ds_src2_addr] != '0);
    w_issue = ds_valid && !(w_hz1 || w_hz2) && es_allowin;
    w_inc   = w_issue && ds_gr_we && (ds_dest != '0);
    w_ret   = ws_rf_we && (ws_rf_waddr != '0);
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_busy = w_busy | (w_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_err <= r_err | (|w_err);
      if (ds_valid && (w_hz1 || w_hz2)) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
    end
  end

  assign ds_ready_go = !(w_hz1 || w_hz2);
  assign sb_busy     = w_busy;
  assign sb_err      = r_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_sb_interlock.sv
// Directed bench for sb_interlock: per-register pending-write model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sb_interlock;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_valid;
  logic        ds_src1_used;
  logic [4:0]  ds_src1_addr;
  logic        ds_src2_used;
  logic [4:0]  ds_src2_addr;
  logic        ds_gr_we;
  logic [4:0]  ds_dest;
  logic        es_allowin;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic        ds_ready_go;
  logic        sb_busy;
  logic        sb_err;
  logic [31:0] stall_cnt;

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;

  int          m_cnt [32];
  bit          m_err;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  sb_interlock dut (
    .clk          (clk),
    .reset        (reset),
    .ds_valid     (ds_valid),
    .ds_src1_used (ds_src1_used),
    .ds_src1_addr (ds_src1_addr),
    .ds_src2_used (ds_src2_used),
    .ds_src2_addr (ds_src2_addr),
    .ds_gr_we     (ds_gr_we),
    .ds_dest      (ds_dest),
    .es_allowin   (es_allowin),
    .ws_rf_we     (ws_rf_we),
    .ws_rf_waddr  (ws_rf_waddr),
    .ds_ready_go  (ds_ready_go),
    .sb_busy      (sb_busy),
    .sb_err       (sb_err),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    bit h1, h2;
    h1 = ds_src1_used && (ds_src1_addr != 0) && (m_cnt[ds_src1_addr] != 0);
    h2 = ds_src2_used && (ds_src2_addr != 0) && (m_cnt[ds_src2_addr] != 0);
    return !(h1 || h2);
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < 32; i++) begin
      if (m_cnt[i] != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: one integer count of outstanding writes per GPR.
  always @(posedge clk) begin : model
    bit rdy, inc, dec;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err   = 1'b0;
      m_stall = 32'd0;
    end else begin
      rdy = m_ready();
      if (ds_valid && !rdy) m_stall = m_stall + 32'd1;
      inc = ds_valid && rdy && es_allowin && ds_gr_we && (ds_dest != 0);
      dec = ws_rf_we && (ws_rf_waddr != 0);
      if (!(inc && dec && (ds_dest == ws_rf_waddr))) begin
        if (inc) begin
          if (m_cnt[ds_dest] == 3) m_err = 1'b1;
          else m_cnt[ds_dest] = m_cnt[ds_dest] + 1;
        end
        if (dec) begin
          if (m_cnt[ws_rf_waddr] == 0) m_err = 1'b1;
          else m_cnt[ws_rf_waddr] = m_cnt[ws_rf_waddr] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("ready_go", {31'd0, ds_ready_go}, {31'd0, m_ready()});
      check("busy",     {31'd0, sb_busy},     {31'd0, m_busy()});
      check("err",      {31'd0, sb_err},      {31'd0, m_err});
      check("stall",    stall_cnt,            m_stall);
    end
  end

  task automatic drive(input bit v, input bit s1u, input logic [4:0] s1a,
                       input bit s2u, input logic [4:0] s2a,
                       input bit we, input logic [4:0] dest, input bit ai,
                       input bit wwe, input logic [4:0] waddr);
    ds_valid     = v;
    ds_src1_used = s1u;
    ds_src1_addr = s1a;
    ds_src2_used = s2u;
    ds_src2_addr = s2a;
    ds_gr_we     = we;
    ds_dest      = dest;
    es_allowin   = ai;
    ws_rf_we     = wwe;
    ws_rf_waddr  = waddr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic retire(input logic [4:0] r);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, r);
  endtask

  initial begin
    reset = 1'b1;
    ds_valid = 0; ds_src1_used = 0; ds_src1_addr = 0; ds_src2_used = 0; ds_src2_addr = 0;
    ds_gr_we = 0; ds_dest = 0; es_allowin = 0; ws_rf_we = 0; ws_rf_waddr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", {31'd0, ds_ready_go}, 32'd1);
    check("rst_busy",  {31'd0, sb_busy},     32'd0);
    check("rst_err",   {31'd0, sb_err},      32'd0);
    check("rst_stall", stall_cnt,            32'd0);

    // RAW: producer writes r5, consumer reads r5 right behind it
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    check("raw_busy", {31'd0, sb_busy}, 32'd1);
    drive(1, 1, 5, 0, 0, 1, 6, 1, 0, 0);
    check("raw_hold1", {31'd0, ds_ready_go}, 32'd0);
    drive(1, 1, 5, 0, 0, 1, 6, 1, 0, 0);
    check("raw_hold2", {31'd0, ds_ready_go}, 32'd0);
    drive(1, 1, 5, 0, 0, 1, 6, 1, 1, 5);
    check("raw_release", {31'd0, ds_ready_go}, 32'd1);
    check("raw_stall_cnt", stall_cnt, 32'd3);
    drive(1, 1, 5, 0, 0, 1, 6, 1, 0, 0);
    idle();
    idle();
    retire(6);
    check("raw_drain", {31'd0, sb_busy}, 32'd0);

    // r0 is never tracked
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    check("r0_busy", {31'd0, sb_busy}, 32'd0);
    drive(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    check("r0_ready", {31'd0, ds_ready_go}, 32'd1);

    // two outstanding writes to r7
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 1, 7);
    check("r7_one_left", {31'd0, ds_ready_go}, 32'd0);
    drive(1, 0, 0, 0, 0, 1, 7, 1, 1, 7);
    check("r7_same_cycle", {31'd0, sb_busy}, 32'd1);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 1, 7);
    check("r7_ready", {31'd0, ds_ready_go}, 32'd1);
    check("r7_busy", {31'd0, sb_busy}, 32'd0);
    check("r7_stall_cnt", stall_cnt, 32'd5);

    // hazard on the second source
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    drive(1, 0, 0, 1, 8, 0, 0, 1, 0, 0);
    check("src2_hold", {31'd0, ds_ready_go}, 32'd0);
    retire(8);
    check("src2_drain", {31'd0, sb_busy}, 32'd0);

    // execute not accepting: no issue, no stall counted
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    check("noallow_busy", {31'd0, sb_busy}, 32'd0);
    check("noallow_stall", stall_cnt, 32'd6);

    // issue and retire to different registers in one cycle
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 4, 1, 1, 3);
    check("diff_busy", {31'd0, sb_busy}, 32'd1);
    retire(4);
    check("diff_drain", {31'd0, sb_busy}, 32'd0);

    // underflow is sticky
    retire(9);
    check("uf_err", {31'd0, sb_err}, 32'd1);
    check("uf_busy", {31'd0, sb_busy}, 32'd0);
    idle();
    idle();
    check("uf_sticky", {31'd0, sb_err}, 32'd1);

    // reset with a write in flight
    drive(1, 0, 0, 0, 0, 1, 11, 1, 0, 0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("mrst_busy", {31'd0, sb_busy}, 32'd0);
    check("mrst_err", {31'd0, sb_err}, 32'd0);
    check("mrst_stall", stall_cnt, 32'd0);

    // overflow: a fourth outstanding write to r12
    repeat (3) drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0);
    check("of_no_err", {31'd0, sb_err}, 32'd0);
    drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0);
    check("of_err", {31'd0, sb_err}, 32'd1);
    repeat (3) retire(12);
    check("of_drain", {31'd0, sb_busy}, 32'd0);
    check("of_sticky", {31'd0, sb_err}, 32'd1);

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_interlock.md
Name: sb_interlock

Overview:
- Register scoreboard and interlock controller for the 5-stage LoongArch pipeline. It replaces the constant-1 ready_go in decode.
- Tracks how many in-flight instructions (EX/MEM/WB) will write each GPR.
- Deasserts ds_ready_go while a source operand of the decode-stage instruction has a pending write, so no instruction reads a stale regfile value.
- Also provides a stall-cycle counter and a sticky consistency-error flag for debug.

Parameters:
- NREG, 32, number of architectural GPRs.
- AW, 5, register address width.
- CNT_W, 2, per-register pending-write counter width (max 3 in flight: EX, MEM, WB).
- PERF_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ds_valid  in  1  decode stage holds a valid instruction
- ds_src1_used  in  1  instruction reads rj
- ds_src1_addr  in  AW  rj address
- ds_src2_used  in  1  instruction reads rk/rd (per src_reg_is_rd)
- ds_src2_addr  in  AW  second source address
- ds_gr_we  in  1  instruction writes a GPR
- ds_dest  in  AW  destination (rd, or 1 for bl)
- es_allowin  in  1  execute stage can accept
- ws_rf_we  in  1  writeback writes regfile this cycle
- ws_rf_waddr  in  AW  writeback address
- ds_ready_go  out  1  decode may issue
- sb_busy  out  1  any counter nonzero
- sb_err  out  1  sticky overflow/underflow flag
- stall_cnt  out  PERF_W  cycles with ds_valid and !ds_ready_go

Behaviour:
- Storage: NREG counters of CNT_W bits. Counter 0 is never incremented; r0 is never a hazard.
- hazard1 = ds_src1_used && src1_addr!=0 && cnt[src1_addr]!=0. hazard2 is the same for src2.
- ds_ready_go = !(hazard1 || hazard2). It is combinational from the current counters, with no same-cycle bypass from ws_rf_we.
  - Rationale: the regfile write lands at the clock edge, so the counter clears on the same edge and the next cycle reads the new value.
- Issue fire: issue = ds_valid && ds_ready_go && es_allowin.
- Increment on issue when ds_gr_we && ds_dest!=0: cnt[ds_dest] += 1 at the clock edge.
- Retire on ws_rf_we && ws_rf_waddr!=0: cnt[ws_rf_waddr] -= 1 at the clock edge.
- Increment and retire to the same register in the same cycle: counter unchanged. Increment and retire to different registers: both apply.
- Overflow: increment at all-ones (and no same-register retire) → counter holds, sb_err <= 1.
- Underflow: retire of a zero counter → counter holds at 0, sb_err <= 1.
- sb_err clears only on reset.
- The scoreboard only blocks issue; it never drops or flushes. A branch that kills the fetch-stage instruction does not involve the scoreboard, because the killed instruction never issued.
- stall_cnt increments by 1 each cycle with ds_valid && !ds_ready_go, and wraps at 2^PERF_W.
- sb_busy = OR of all counters, registered-free (combinational from the counters).
- Reset: all counters 0, sb_err=0, stall_cnt=0.
  - Resulting outputs: ds_ready_go=1 (no hazards), sb_busy=0.
- Reset asserted mid-operation clears all state in the next cycle regardless of in-flight writes. The pipeline stages reset in the same cycle, so no stale retire can follow.
- Latency: a dependent instruction directly behind its producer stalls exactly 3 cycles (producer in EX, MEM, WB) with es_allowin=1 throughout.

Decomposition:
- Shared package/header (mycpu.h): AW and NREG as `define constants, next to the existing bus widths.
- One natural sub-module: sb_counter (a single CNT_W up/down saturating counter with err output), instantiated NREG-1 times in a generate loop.
- The top level holds the hazard compare, the issue/retire decode and the perf counter.
- The decode stage instantiates sb_interlock and drives its ds_ready_go from the block.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → ds_ready_go=1, sb_busy=0, stall_cnt=0, sb_err=0.
- RAW back-to-back: issue add.w r5 (gr_we, dest 5), next inst reads rj=5 → ds_ready_go=0 for 3 cycles. The counter is released by ws_rf_we to r5, and ds_ready_go=1 on cycle 4. stall_cnt=3.
- r0 immunity: issue dest=0, then a source rj=0 → no stall, all counters stay 0.
- Two writes to r7 in flight: issue dest 7 twice (cnt=2), retire once → still stalled on rj=7; second retire → ready. Same-cycle issue(dest 7)+retire(r7) leaves cnt unchanged.
- Stall with es_allowin=0: no hazard, es_allowin=0 → ds_ready_go=1, no increment, and stall_cnt does not increment.
- Error injection: ws_rf_we to r9 with cnt[9]=0 → sb_err=1 next cycle, cnt[9] stays 0; sb_err stays 1 until reset.
